// File: rtl/npc_mem_arbiter_if.sv
// Signal bundle between the IFU/LSU requesters, the memory arbiter and the
// DPI-backed pmem port. The arbiter takes the slave side, its environment the master.
interface npc_mem_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic        if_resp_ready;
  logic [63:0] if_resp_data;

  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [63:0] ls_req_addr;
  logic        ls_req_wen;
  logic [63:0] ls_req_wdata;
  logic [7:0]  ls_req_wmask;
  logic        ls_resp_valid;
  logic        ls_resp_ready;
  logic [63:0] ls_resp_data;

  logic [63:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;

  modport slave (
    input  if_req_valid, if_req_addr, if_resp_ready,
    input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_resp_ready,
    input  mem_rdata,
    output if_req_ready, if_resp_valid, if_resp_data,
    output ls_req_ready, ls_resp_valid, ls_resp_data,
    output mem_raddr, mem_waddr, mem_wdata, mem_wmask
  );

  modport master (
    output if_req_valid, if_req_addr, if_resp_ready,
    output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_resp_ready,
    output mem_rdata,
    input  if_req_ready, if_resp_valid, if_resp_data,
    input  ls_req_ready, ls_resp_valid, ls_resp_data,
    input  mem_raddr, mem_waddr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/npc_mem_arbiter.sv
// Round-robin arbiter and sequencer sharing the single pmem port between the
// instruction fetch unit (read-only) and the load/store unit (read/write).
module npc_mem_arbiter #(
  parameter int unsigned MEM_LAT   = 1,
  parameter logic [63:0] IDLE_ADDR = 64'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  npc_mem_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  owner_e           r_owner;
  owner_e           r_last_grant;
  logic [63:0]      r_addr;
  logic             r_wen;
  logic [63:0]      r_mem_waddr;
  logic [63:0]      r_mem_wdata;
  logic [7:0]       r_mem_wmask;
  logic [63:0]      r_resp_data;

  logic             w_grant_if;
  logic             w_grant_ls;
  logic             w_store_accept;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_if        = 1'b0;
    w_grant_ls        = 1'b0;
    bus.if_req_ready  = 1'b0;
    bus.ls_req_ready  = 1'b0;
    bus.if_resp_valid = 1'b0;
    bus.ls_resp_valid = 1'b0;

    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not win last time goes first.
        w_grant_if       = bus.if_req_valid &
                           (~bus.ls_req_valid | (r_last_grant == OWN_LS));
        w_grant_ls       = bus.ls_req_valid & ~w_grant_if;
        bus.if_req_ready = w_grant_if & ~rst;
        bus.ls_req_ready = w_grant_ls & ~rst;
        if (w_grant_if | w_grant_ls) w_state_nxt = S_ACCESS;
      end

      S_ACCESS: begin
        if (r_cnt == '0) w_state_nxt = S_RESP;
      end

      S_RESP: begin
        bus.if_resp_valid = (r_owner == OWN_IF) & ~rst;
        bus.ls_resp_valid = (r_owner == OWN_LS) & ~rst;
        if ((r_owner == OWN_IF) ? bus.if_resp_ready : bus.ls_resp_ready)
          w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_store_accept = w_grant_ls & bus.ls_req_wen;

  // NOTE: only control and port-holding registers exist here (no storage
  // arrays), so every one of them gets an explicit reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_owner      <= OWN_IF;
      r_last_grant <= OWN_LS;
      r_addr       <= IDLE_ADDR;
      r_wen        <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
      r_mem_wmask  <= '0;
      r_resp_data  <= '0;
    end else begin
      r_mem_wmask <= '0;

      if (w_grant_if | w_grant_ls) begin
        r_owner      <= w_grant_ls ? OWN_LS : OWN_IF;
        r_last_grant <= w_grant_ls ? OWN_LS : OWN_IF;
        r_addr       <= w_grant_ls ? bus.ls_req_addr : bus.if_req_addr;
        r_wen        <= w_store_accept;
        r_cnt        <= CNT_INIT;
      end

      // The strobe is loaded at accept so it is live in the first ACCESS
      // cycle only; a reset landing before that cycle suppresses it.
      if (w_store_accept) begin
        r_mem_waddr <= bus.ls_req_addr;
        r_mem_wdata <= bus.ls_req_wdata;
        r_mem_wmask <= bus.ls_req_wmask;
      end

      if (r_state == S_ACCESS) begin
        if (r_cnt != '0) r_cnt       <= r_cnt - CNT_W'(1);
        else             r_resp_data <= r_wen ? 64'h0 : bus.mem_rdata;
      end
    end
  end

  assign bus.mem_raddr    = r_addr;
  assign bus.mem_waddr    = r_mem_waddr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_wmask    = r_mem_wmask;
  assign bus.if_resp_data = r_resp_data;
  assign bus.ls_resp_data = r_resp_data;

endmodule
